// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot-time front end of the single-cycle MIPS core. It accepts a framed
//   byte stream over a valid/ready handshake and assembles big-endian 32-bit
//   words, writing each one into instruction memory. The core is held in
//   reset until a whole frame has been stored and its checksum matches.
//
//   Frame: 0xA5, LEN_HI, LEN_LO, 4*N data bytes (MSB first), CSUM
//   CSUM = XOR of LEN_HI, LEN_LO and every data byte (the sync byte is excluded).
//
// Parameters
//   ADDR_W      instruction-memory word-address width (1..16); max program 2**ADDR_W words
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    in_data holds a byte
//   in_data     stream byte
//   in_ready    loader accepts a byte this cycle (transfer = in_valid & in_ready)
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word address of the write
//   imem_wdata  assembled instruction word
//   cpu_rst     active-high reset to the core, released only after a good frame
//   done        frame loaded and checksum good (sticky until rst)
//   error       bad length or bad checksum (sticky until rst)
module imem_boot_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_SYNC, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    // Largest legal word count; 17 bits so a 16-bit length never overflows the compare.
    localparam logic [16:0] MAX_N = 17'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [ADDR_W:0]   n_words_q, n_words_d;
    // One bit wider than the address so N = 2**ADDR_W is reachable without wrapping.
    logic [ADDR_W:0]   word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       word_q, word_d;
    logic [7:0]        xor_q, xor_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic [16:0]       len_full;

    assign xfer     = in_valid & in_ready_q;
    assign len_full = {1'b0, len_hi_q, in_data};

    always_comb begin
        state_d      = state_q;
        len_hi_d     = len_hi_q;
        n_words_d    = n_words_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        xor_d        = xor_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_d    = cpu_rst_q;
        done_d       = done_q;
        error_d      = error_q;

        if (xfer) begin
            case (state_q)
                S_SYNC: begin
                    if (in_data == 8'hA5) state_d = S_LEN_HI;
                end
                S_LEN_HI: begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
                S_LEN_LO: begin
                    if (len_full == 17'd0 || len_full > MAX_N) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d    = S_DATA;
                        n_words_d  = len_full[ADDR_W:0];
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        xor_d      = len_hi_q ^ in_data;
                    end
                end
                S_DATA: begin
                    word_d     = {word_q[15:0], in_data};
                    xor_d      = xor_q ^ in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_idx_q[ADDR_W-1:0];
                        imem_wdata_d = {word_q, in_data};
                        word_idx_d   = word_idx_q + (ADDR_W+1)'(1);
                        if (word_idx_q + (ADDR_W+1)'(1) == n_words_q) state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (in_data == xor_q) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Registered ready mirrors the state the FSM is about to be in.
        in_ready_d = (state_d != S_DONE) && (state_d != S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_SYNC;
            len_hi_q     <= '0;
            n_words_q    <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            xor_q        <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_q    <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            n_words_q    <= n_words_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            xor_q        <= xor_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_q    <= cpu_rst_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
//   Directed and randomized frames for imem_boot_loader. A reference parser
//   reads the byte stream and predicts the memory writes and final status;
//   a negedge monitor captures every write strobe.
module tb_imem_boot_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              error;

    imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [7:0]  stream[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic        exp_done;
    logic        exp_err;

    logic [ADDR_W-1:0] cap_addr[$];
    logic [31:0]       cap_data[$];
    int  cyc = 0;
    bit  prev_xfer = 1'b0;
    int  lat_err = 0;
    int  last_we_cyc = -1;
    int  rst_fall_cyc = -1;
    logic prev_cpu_rst = 1'b1;

    // Write monitor: a strobe must follow a byte transfer on the previous edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (imem_we) begin
            cap_addr.push_back(imem_addr);
            cap_data.push_back(imem_wdata);
            last_we_cyc = cyc;
            if (!prev_xfer) lat_err = lat_err + 1;
        end
        if (prev_cpu_rst && !cpu_rst) rst_fall_cyc = cyc;
        prev_cpu_rst = cpu_rst;
        prev_xfer = in_valid && in_ready;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_imem_we", 32'(imem_we), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_cpu_rst", 32'(cpu_rst), 1);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(in_ready), 1);
    endtask

    // mode 0: back-to-back, 1: valid low every other cycle, 2: random gaps
    task automatic send(input logic [7:0] b, input int mode);
        int g;
        g = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("send_timeout_ready", 32'(in_ready), 1);
    endtask

    // Reference parser: find the sync byte, read the length, slice words, fold the XOR.
    task automatic model();
        int i;
        int n;
        logic [7:0]  x;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        i = 0;
        while (i < stream.size() && stream[i] != 8'hA5) i++;
        if (i + 2 >= stream.size()) return;
        n = int'(stream[i+1]) * 256 + int'(stream[i+2]);
        if (n == 0 || n > (1 << ADDR_W)) begin
            exp_err = 1'b1;
            return;
        end
        x = stream[i+1] ^ stream[i+2];
        for (int k = 0; k < n; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                w = (w << 8) | 32'(stream[i+3+4*k+j]);
                x = x ^ stream[i+3+4*k+j];
            end
            exp_addr.push_back(k);
            exp_data.push_back(w);
        end
        exp_done = (stream[i+3+4*n] == x);
        exp_err  = !exp_done;
    endtask

    task automatic mk_frame(input int n, input bit count_words, input bit bad);
        logic [7:0]  x;
        logic [31:0] w;
        stream.push_back(8'hA5);
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        x = 8'(n >> 8) ^ 8'(n);
        for (int k = 0; k < n; k++) begin
            w = count_words ? 32'(k) : $urandom;
            for (int j = 3; j >= 0; j--) begin
                stream.push_back(w[8*j +: 8]);
                x = x ^ w[8*j +: 8];
            end
        end
        stream.push_back(bad ? ~x : x);
    endtask

    task automatic run_frame(input string tag, input int mode);
        model();
        cap_addr.delete();
        cap_data.delete();
        last_we_cyc  = -1;
        rst_fall_cyc = -1;
        lat_err      = 0;
        foreach (stream[i]) send(stream[i], mode);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
        repeat (2) @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_nwrites"}, 32'(cap_addr.size()), 32'(exp_addr.size()));
        for (int k = 0; k < exp_addr.size() && k < cap_addr.size(); k++) begin
            check({tag, "_addr"}, 32'(cap_addr[k]), 32'(exp_addr[k]));
            check({tag, "_wdata"}, cap_data[k], exp_data[k]);
        end
        check({tag, "_we_latency"}, 32'(lat_err), 0);
        if (exp_done)
            check({tag, "_we_before_release"}, 32'(last_we_cyc < rst_fall_cyc), 1);
        @(posedge clk); #1;
    endtask

    initial begin
        // Good frame
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'h20, 8'h09, 8'h00, 8'h07, 8'h01};
        run_frame("good", 0);
        check("good_word0", cap_data.size() > 0 ? cap_data[0] : 32'hx, 32'h2008_0005);
        check("good_done_const", 32'(done), 1);

        // Same frame, bad checksum
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'h20, 8'h09, 8'h00, 8'h07, 8'h00};
        run_frame("badcsum", 0);
        check("badcsum_error_const", 32'(error), 1);

        // Leading garbage
        do_reset();
        stream = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
                   8'h05, 8'h20, 8'h09, 8'h00, 8'h07, 8'h01};
        run_frame("garbage", 0);

        // Zero length
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h00};
        run_frame("len0", 0);

        // Oversized length (257 words)
        do_reset();
        stream = '{8'hA5, 8'h01, 8'h01};
        run_frame("len257", 0);

        // Gaps every other cycle, then reset mid-DATA, then a fresh frame
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                   8'h20, 8'h09, 8'h00, 8'h07, 8'h01};
        run_frame("gaps", 1);
        do_reset();
        stream = '{8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (stream[i]) send(stream[i], 0);
        check("mid_cpu_rst_held", 32'(cpu_rst), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_cpu_rst", 32'(cpu_rst), 1);
        check("mid_rst_in_ready", 32'(in_ready), 0);
        check("mid_rst_done", 32'(done), 0);
        @(posedge clk); #1;
        check("mid_rst_ready_back", 32'(in_ready), 1);
        stream.delete();
        mk_frame(3, 1'b0, 1'b0);
        run_frame("after_mid_rst", 2);

        // Full-size program: 256 words, word k = k
        do_reset();
        stream.delete();
        mk_frame(256, 1'b1, 1'b0);
        run_frame("n256", 0);
        check("n256_last_addr", cap_addr.size() > 0 ? 32'(cap_addr[cap_addr.size()-1]) : 32'hx, 32'hFF);

        // Randomized frames with optional garbage prefix and checksum corruption
        for (int r = 0; r < 8; r++) begin
            do_reset();
            stream.delete();
            repeat ($urandom_range(0, 3)) stream.push_back(8'($urandom_range(0, 8'hA4)));
            mk_frame(int'($urandom_range(1, 8)), 1'b0, ($urandom_range(0, 2) == 0));
            run_frame("rand", 2);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
